fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC loaded by reset; bits[1:0] SHALL be 0.
REQ-002 clk_in  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_in  input  1  synchronous, active-high reset.
REQ-004 pc_reload_in  input  1  redirect request (branch/trap) from later stage.
REQ-005 pc_reload_addr_in  input  32  redirect target.
REQ-006 ic_req_out  output  1  instruction-memory request.
REQ-007 ic_addr_out  output  32  request address.
REQ-008 ic_ack_in  input  1  memory response valid; single-cycle pulse, only while ic_req_out=1.
REQ-009 ic_rd_data_in  input  32  instruction word, valid with ic_ack_in.
REQ-010 ic_fault_in  input  1  access fault, valid with ic_ack_in.
REQ-011 fet_wr_out  output  1  write strobe to downstream pipe (its write_in).
REQ-012 fet_data_out  output  F2D_TYPE  {pc[31:0], instr[31:0], fault} to downstream pipe.
REQ-013 pipe_full_in  input  1  downstream pipe full_out.
REQ-014 pipe_read_in  input  1  downstream pipe read_in; can_accept = !pipe_full_in | pipe_read_in.

Function
REQ-015 States SHALL be IDLE, REQ, WAIT_PIPE, DISCARD.
REQ-016 IDLE: outputs quiet; next cycle -> REQ.
REQ-017 REQ: ic_req_out=1, ic_addr_out=req_addr; on ic_ack_in capture {req_addr, ic_rd_data_in, ic_fault_in} into hold register, pc <= pc+4, -> WAIT_PIPE.
REQ-018 ic_req_out and ic_addr_out SHALL stay constant from assertion until the ack cycle inclusive; a request is never withdrawn.
REQ-019 WAIT_PIPE: fet_wr_out = can_accept; fet_data_out = hold register; on fet_wr_out=1 -> REQ next cycle with req_addr = pc.
REQ-020 fet_wr_out SHALL never assert when !can_accept, nor in any state except WAIT_PIPE.
REQ-021 Latency: ack in cycle N -> fet_wr_out earliest N+1 -> next ic_req_out earliest N+2; peak 1 instruction / 2 cycles.
REQ-022 PC increment SHALL wrap mod 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-023 pc_reload_in in any state SHALL load pc <= {pc_reload_addr_in[31:2], 2'b00}.
REQ-024 Reload in REQ without ack: -> DISCARD, request remains asserted at old address.
REQ-025 Reload in REQ with ack same cycle: response dropped, hold not written, -> REQ with new address next cycle.
REQ-026 DISCARD: ic_req_out=1 at old address; ack dropped -> REQ at reloaded pc; further reloads update pc, remain DISCARD.
REQ-027 Reload in WAIT_PIPE: fet_wr_out forced 0 that cycle, hold invalidated, -> REQ.
REQ-028 Reload in IDLE: pc loaded, -> REQ.
REQ-029 Fault responses SHALL be passed downstream unchanged with fault=1; fetch continues at pc+4.

Reset
REQ-030 reset_in=1: state IDLE, pc=RESET_PC, ic_req_out=0, fet_wr_out=0, hold invalid, fet_data_out=0; reset SHALL override reload and ack in the same cycle, including mid-request (outstanding ack after reset is ignored in IDLE).

Structure
REQ-031 F2D_TYPE SHALL be defined in cpu_structs_pkg; RESET_PC default constant in cpu_params_pkg.
REQ-032 No sub-module; downstream pipe is instantiated by the parent, not inside fetch_stage.

Verification
REQ-033 Reset release, RESET_PC=0, ack 2 cycles after each request, can_accept=1 -> fetch addresses 0x0,0x4,0x8; fet_wr_out one cycle after each ack.
REQ-034 pipe_full_in=1, pipe_read_in=0 for 5 cycles in WAIT_PIPE -> fet_wr_out=0, no ic_req_out; release -> one write, then request at next PC.
REQ-035 Reload to 0x0000_1003 while request to 0x10 outstanding, ack 3 cycles later -> that ack dropped, next request to 0x0000_1000, no fet_wr_out for 0x10.
REQ-036 pc=0xFFFF_FFFC, ack -> next request address 0x0000_0000.
REQ-037 Ack with ic_fault_in=1 at 0x20 -> fet_data_out {pc=0x20, fault=1}, next request 0x24.
REQ-038 reset_in asserted same cycle as ack and reload -> next cycle IDLE, pc=RESET_PC, fet_wr_out=0.

Source files
------------

// File: rtl/cpu_params_pkg.sv
// Core-wide constants shared by the pipeline stages.
// Holds the default reset PC for the fetch stage.
package cpu_params_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

endpackage

// File: rtl/cpu_structs_pkg.sv
// Inter-stage bundles and state encodings shared by the pipeline.
// F2D_TYPE carries one fetched instruction to decode.
package cpu_structs_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } F2D_TYPE;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_REQ     = 2'd1,
    FS_WAIT    = 2'd2,
    FS_DISCARD = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding memory request, a single hold
// register toward the decode pipe, and redirect handling.
module fetch_stage
  import cpu_params_pkg::*;
  import cpu_structs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        pc_reload_in,
  input  logic [31:0] pc_reload_addr_in,
  output logic        ic_req_out,
  output logic [31:0] ic_addr_out,
  input  logic        ic_ack_in,
  input  logic [31:0] ic_rd_data_in,
  input  logic        ic_fault_in,
  output logic        fet_wr_out,
  output F2D_TYPE     fet_data_out,
  input  logic        pipe_full_in,
  input  logic        pipe_read_in
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  req_addr_q;
  F2D_TYPE      hold_q;
  logic         hold_vld_q;

  logic         can_accept;
  logic [31:0]  reload_pc;
  logic [31:0]  pc_sel;
  logic         in_req;
  logic         in_wait;

  assign can_accept = !pipe_full_in | pipe_read_in;
  assign reload_pc  = word_align(pc_reload_addr_in);
  assign pc_sel     = pc_reload_in ? reload_pc : pc_q;

  assign in_req  = (state_q == FS_REQ) | (state_q == FS_DISCARD);
  assign in_wait = (state_q == FS_WAIT);

  assign ic_req_out  = in_req;
  assign ic_addr_out = in_req ? req_addr_q : 32'h0;

  // A redirect or reset in the same cycle kills the pending write.
  assign fet_wr_out = in_wait & hold_vld_q & can_accept
                    & !pc_reload_in & !reset_in;

  assign fet_data_out = hold_q;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= FS_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      unique case (state_q)
        FS_IDLE: begin
          pc_q       <= pc_sel;
          req_addr_q <= pc_sel;
          state_q    <= FS_REQ;
        end
        FS_REQ: begin
          if (pc_reload_in) begin
            pc_q <= reload_pc;
            if (ic_ack_in) begin
              req_addr_q <= reload_pc;
              state_q    <= FS_REQ;
            end else begin
              state_q <= FS_DISCARD;
            end
          end else if (ic_ack_in) begin
            hold_q.pc    <= req_addr_q;
            hold_q.instr <= ic_rd_data_in;
            hold_q.fault <= ic_fault_in;
            hold_vld_q   <= 1'b1;
            pc_q         <= pc_q + INSTR_BYTES;
            state_q      <= FS_WAIT;
          end
        end
        FS_WAIT: begin
          if (pc_reload_in) begin
            pc_q       <= reload_pc;
            req_addr_q <= reload_pc;
            hold_vld_q <= 1'b0;
            state_q    <= FS_REQ;
          end else if (fet_wr_out) begin
            req_addr_q <= pc_q;
            hold_vld_q <= 1'b0;
            state_q    <= FS_REQ;
          end
        end
        FS_DISCARD: begin
          pc_q <= pc_sel;
          // The stale response retires the old request; fetch resumes.
          if (ic_ack_in) begin
            req_addr_q <= pc_sel;
            state_q    <= FS_REQ;
          end
        end
        default: state_q <= FS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory responder, transaction scoreboard,
// directed scenarios and a randomized run.
module tb_fetch_stage;
  import cpu_structs_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        pc_reload_in = 1'b0;
  logic [31:0] pc_reload_addr_in = '0;
  logic        ic_req_out;
  logic [31:0] ic_addr_out;
  logic        ic_ack_in = 1'b0;
  logic [31:0] ic_rd_data_in = '0;
  logic        ic_fault_in = 1'b0;
  logic        fet_wr_out;
  F2D_TYPE     fet_data_out;
  logic        pipe_full_in = 1'b0;
  logic        pipe_read_in = 1'b0;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .pc_reload_in(pc_reload_in),
    .pc_reload_addr_in(pc_reload_addr_in),
    .ic_req_out(ic_req_out),
    .ic_addr_out(ic_addr_out),
    .ic_ack_in(ic_ack_in),
    .ic_rd_data_in(ic_rd_data_in),
    .ic_fault_in(ic_fault_in),
    .fet_wr_out(fet_wr_out),
    .fet_data_out(fet_data_out),
    .pipe_full_in(pipe_full_in),
    .pipe_read_in(pipe_read_in)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int mem_lat = 1;
  int mem_cnt = 0;
  bit rand_fault = 1'b0;

  logic [31:0] exp_fetch = RST_PC;
  logic [31:0] cur_addr = '0;
  bit          req_active = 1'b0;
  bit          squash = 1'b0;
  bit          pend_vld = 1'b0;
  bit          exp_req_next = 1'b0;
  bit          exp_quiet = 1'b0;
  F2D_TYPE     pend = '0;

  bit          o_req, o_wr, o_ack, o_newreq;
  logic [31:0] o_addr;
  F2D_TYPE     o_data;
  int          o_cyc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0F1E_2D3C;
  endfunction

  // One clock cycle: drive, sample, score, then advance the model.
  task automatic step(input bit rst, input bit rl, input logic [31:0] rla,
                      input bit full, input bit rd, input bit flt);
    bit ack, acc, ewr, idle;
    @(negedge clk_in);
    ack = ic_req_out && (mem_cnt >= mem_lat);
    reset_in = rst;
    pc_reload_in = rl;
    pc_reload_addr_in = rla;
    pipe_full_in = full;
    pipe_read_in = rd;
    ic_ack_in = ack;
    ic_rd_data_in = ack ? mem_word(ic_addr_out) : $urandom;
    ic_fault_in = ack ? (flt | (rand_fault && $urandom_range(0, 5) == 0))
                      : 1'($urandom_range(0, 1));
    #1;
    acc = !full || rd;
    idle = exp_quiet;
    o_req = ic_req_out;
    o_addr = ic_addr_out;
    o_wr = fet_wr_out;
    o_data = fet_data_out;
    o_ack = ack;
    o_newreq = ic_req_out && !req_active;
    o_cyc = cyc;

    if (ic_req_out && !req_active) begin
      checks++;
      if (ic_addr_out !== exp_fetch) begin
        errors++;
        $display("FAIL req_addr cyc=%0d got %h want %h", cyc, ic_addr_out, exp_fetch);
      end
    end
    if (req_active) begin
      checks++;
      if (ic_req_out !== 1'b1 || ic_addr_out !== cur_addr) begin
        errors++;
        $display("FAIL req_hold cyc=%0d got %b/%h want 1/%h", cyc, ic_req_out, ic_addr_out, cur_addr);
      end
    end
    if (exp_req_next) begin
      checks++;
      if (ic_req_out !== 1'b1) begin
        errors++;
        $display("FAIL req_latency cyc=%0d got %b want 1", cyc, ic_req_out);
      end
    end
    if (idle) begin
      checks++;
      if (ic_req_out !== 1'b0 || fet_wr_out !== 1'b0 || fet_data_out !== F2D_TYPE'(0)) begin
        errors++;
        $display("FAIL idle_quiet cyc=%0d got req=%b wr=%b data=%h want 0/0/0", cyc, ic_req_out, fet_wr_out, fet_data_out);
      end
    end
    if (pend_vld) begin
      checks++;
      if (ic_req_out !== 1'b0) begin
        errors++;
        $display("FAIL req_while_holding cyc=%0d got %b want 0", cyc, ic_req_out);
      end
    end
    ewr = pend_vld && acc && !rl && !rst;
    checks++;
    if (fet_wr_out !== ewr) begin
      errors++;
      $display("FAIL wr_strobe cyc=%0d got %b want %b", cyc, fet_wr_out, ewr);
    end
    if (ewr && fet_wr_out) begin
      checks++;
      if (fet_data_out !== pend) begin
        errors++;
        $display("FAIL wr_data cyc=%0d got %h want %h", cyc, fet_data_out, pend);
      end
    end

    exp_req_next = 1'b0;
    exp_quiet = 1'b0;
    if (rst) begin
      exp_fetch = RST_PC;
      req_active = 1'b0;
      squash = 1'b0;
      pend_vld = 1'b0;
      exp_quiet = 1'b1;
      mem_cnt = 0;
    end else begin
      if (ic_req_out && !req_active) begin
        req_active = 1'b1;
        cur_addr = ic_addr_out;
      end
      if (ewr) begin
        pend_vld = 1'b0;
        exp_req_next = 1'b1;
      end
      if (rl) begin
        exp_fetch = {rla[31:2], 2'b00};
        if (pend_vld) exp_req_next = 1'b1;
        pend_vld = 1'b0;
        if (req_active) squash = 1'b1;
      end
      if (idle) exp_req_next = 1'b1;
      if (ack) begin
        req_active = 1'b0;
        if (squash) begin
          squash = 1'b0;
          exp_req_next = 1'b1;
        end else begin
          pend = '{pc: cur_addr, instr: ic_rd_data_in, fault: ic_fault_in};
          pend_vld = 1'b1;
          exp_fetch = cur_addr + 32'd4;
        end
      end
      if (ack) mem_cnt = 0;
      else if (ic_req_out) mem_cnt++;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rand_fault = 1'b0;
    repeat (2) step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (o_req !== 1'b0 || o_wr !== 1'b0 || o_data !== F2D_TYPE'(0)) begin
      errors++;
      $display("FAIL reset_state got req=%b wr=%b data=%h want 0/0/0", o_req, o_wr, o_data);
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (o_req !== 1'b1 || o_addr !== RST_PC) begin
      errors++;
      $display("FAIL first_req got %b/%h want 1/%h", o_req, o_addr, RST_PC);
    end
  endtask

  task automatic test_basic();
    logic [31:0] addrs[$];
    int last_ack = -10;
    int last_wr = -10;
    int nwr = 0;
    do_reset();
    mem_lat = 2;
    for (int i = 0; i < 40 && nwr < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (o_newreq) begin
        addrs.push_back(o_addr);
        if (last_wr >= 0) begin
          checks++;
          if (o_cyc !== last_wr + 1) begin
            errors++;
            $display("FAIL basic_req_gap got %0d want %0d", o_cyc, last_wr + 1);
          end
        end
      end
      if (o_ack) last_ack = o_cyc;
      if (o_wr) begin
        nwr++;
        last_wr = o_cyc;
        checks++;
        if (o_cyc !== last_ack + 1) begin
          errors++;
          $display("FAIL basic_wr_latency got %0d want %0d", o_cyc, last_ack + 1);
        end
      end
    end
    checks++;
    if (nwr != 3 || addrs.size() < 3) begin
      errors++;
      $display("FAIL basic_count got %0d writes want 3", nwr);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (addrs[k] !== 32'(4 * k)) begin
          errors++;
          $display("FAIL basic_addr%0d got %h want %h", k, addrs[k], 32'(4 * k));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a = '0;
    bit got = 1'b0;
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (o_ack) begin got = 1'b1; a = o_addr; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL bp_ack_timeout got 0 want 1");
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 0, 0);
      checks++;
      if (o_wr !== 1'b0 || o_req !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall got wr=%b req=%b want 0/0", o_wr, o_req);
      end
    end
    step(0, 0, 0, 1, 1, 0);
    checks++;
    if (o_wr !== 1'b1 || o_data.pc !== a) begin
      errors++;
      $display("FAIL bp_release got wr=%b pc=%h want 1/%h", o_wr, o_data.pc, a);
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (o_req !== 1'b1 || o_addr !== a + 32'd4) begin
      errors++;
      $display("FAIL bp_next_req got %b/%h want 1/%h", o_req, o_addr, a + 32'd4);
    end
  endtask

  task automatic test_reload_discard();
    bit got = 1'b0;
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < 60 && !got; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (o_newreq && o_addr == 32'h10) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rl_reach_timeout got 0 want 1");
    end
    mem_lat = 4;
    step(0, 1, 32'h0000_1003, 0, 0, 0);
    checks++;
    if (o_req !== 1'b1 || o_addr !== 32'h10 || o_ack) begin
      errors++;
      $display("FAIL rl_hold got %b/%h ack=%b want 1/00000010/0", o_req, o_addr, o_ack);
    end
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      checks++;
      if (o_req !== 1'b1 || o_addr !== 32'h10 || o_wr !== 1'b0 || o_ack !== (i == 3)) begin
        errors++;
        $display("FAIL rl_discard%0d got req=%b addr=%h wr=%b ack=%b", i, o_req, o_addr, o_wr, o_ack);
      end
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (o_req !== 1'b1 || o_addr !== 32'h0000_1000 || o_wr !== 1'b0) begin
      errors++;
      $display("FAIL rl_new_req got %b/%h wr=%b want 1/00001000/0", o_req, o_addr, o_wr);
    end
  endtask

  task automatic test_wrap();
    bit got = 1'b0;
    do_reset();
    mem_lat = 1;
    step(0, 1, 32'hFFFF_FFFE, 0, 0, 0);
    for (int i = 0; i < 20 && !got; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (o_wr) begin
        got = 1'b1;
        checks++;
        if (o_data.pc !== 32'hFFFF_FFFC) begin
          errors++;
          $display("FAIL wrap_pc got %h want fffffffc", o_data.pc);
        end
      end
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (!got || o_req !== 1'b1 || o_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next got %b/%h want 1/00000000", o_req, o_addr);
    end
  endtask

  task automatic test_fault();
    bit got = 1'b0;
    F2D_TYPE want;
    do_reset();
    mem_lat = 2;
    want = '{pc: 32'h20, instr: mem_word(32'h20), fault: 1'b1};
    step(0, 1, 32'h20, 0, 0, 0);
    for (int i = 0; i < 20 && !got; i++) begin
      step(0, 0, 0, 0, 0, 1);
      if (o_wr) begin
        got = 1'b1;
        checks++;
        if (o_data !== want) begin
          errors++;
          $display("FAIL fault_data got %h want %h", o_data, want);
        end
      end
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (!got || o_req !== 1'b1 || o_addr !== 32'h24) begin
      errors++;
      $display("FAIL fault_next got %b/%h want 1/00000024", o_req, o_addr);
    end
  endtask

  task automatic test_reset_collision();
    do_reset();
    mem_lat = 0;
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h0000_0500, 0, 0, 0);
    checks++;
    if (o_ack !== 1'b1 || o_req !== 1'b1) begin
      errors++;
      $display("FAIL coll_setup got ack=%b req=%b want 1/1", o_ack, o_req);
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (o_req !== 1'b0 || o_wr !== 1'b0 || o_data !== F2D_TYPE'(0)) begin
      errors++;
      $display("FAIL coll_idle got req=%b wr=%b data=%h want 0/0/0", o_req, o_wr, o_data);
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (o_req !== 1'b1 || o_addr !== RST_PC) begin
      errors++;
      $display("FAIL coll_restart got %b/%h want 1/%h", o_req, o_addr, RST_PC);
    end
  endtask

  task automatic test_random();
    int nwr = 0;
    do_reset();
    rand_fault = 1'b1;
    mem_lat = 1;
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 149) == 0,
           $urandom_range(0, 15) == 0,
           $urandom,
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           1'b0);
      if (o_ack) mem_lat = $urandom_range(0, 3);
      if (o_wr) nwr++;
    end
    checks++;
    if (nwr < 100) begin
      errors++;
      $display("FAIL rand_progress got %0d writes want >=100", nwr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reload_discard();
    test_wrap();
    test_fault();
    test_reset_collision();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
